// File: rtl/clock_set_ctrl.sv
// Purpose : 24-hour HH:MM:SS time-of-day source in packed BCD, with key-driven field editing.
// Latency : one cycle; a key pulse or tick sampled at edge N is visible after edge N.
// Backpress: none; every key pulse is consumed in the cycle it is seen.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   key_mode          - debounced pulse, steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
//   key_inc, key_dec  - debounced pulses, +1 / -1 on the field selected in a SET state
//   number_BCD[23:0]  - {H1,H0,M1,M0,S1,S0}; [3:0] is the seconds units digit
//   enable[5:0]       - per-digit enable; bit i pairs with number_BCD[4i+3:4i]
//   twinkle[5:0]      - per-digit blink request for the field being edited
//   set_mode[1:0]     - 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//
// Build option: define CLOCK_SET_LZB_EN to blank the hour tens digit when it is zero
// (kept visible while editing hours). Without it, enable is constant 6'b111111.
// CLK_DIV must be at least 2 and fit in the 26-bit prescaler.

module clock_set_ctrl #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_dec,
  output logic [23:0] number_BCD,
  output logic [5:0]  enable,
  output logic [5:0]  twinkle,
  output logic [1:0]  set_mode
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  localparam logic [25:0] PRESC_LAST = 26'(CLK_DIV - 1);
  localparam logic [7:0]  HOUR_MAX   = 8'h23;
  localparam logic [7:0]  MS_MAX     = 8'h59;

`ifdef CLOCK_SET_LZB_EN
  localparam logic [5:0] ENABLE_RST = 6'b011111;
`else
  localparam logic [5:0] ENABLE_RST = 6'b111111;
`endif

  // Two-digit BCD increment that wraps max_v -> 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Two-digit BCD decrement that wraps 00 -> max_v.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = max_v;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  hour_q, hour_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  sec_q, sec_d;
  logic [25:0] presc_q, presc_d;
  logic [5:0]  twinkle_q, twinkle_d;
  logic [5:0]  enable_q, enable_d;

  logic tick;
  logic do_inc;
  logic do_dec;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;

    // The prescaler only runs in RUN, so a tick can never fire while editing.
    tick   = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    // inc and dec together cancel; key_mode wins over either.
    do_inc = key_inc && !key_dec && !key_mode;
    do_dec = key_dec && !key_inc && !key_mode;

    unique case (state_q)
      ST_RUN: begin
        // The tick is still applied when key_mode arrives in the same cycle.
        if (tick) begin
          sec_d = bcd_inc(sec_q, MS_MAX);
          if (sec_q == MS_MAX) begin
            min_d = bcd_inc(min_q, MS_MAX);
            if (min_q == MS_MAX) begin
              hour_d = bcd_inc(hour_q, HOUR_MAX);
            end
          end
        end
        if (key_mode) begin
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        if (key_mode) begin
          state_d = ST_SET_MIN;
        end else if (do_inc) begin
          hour_d = bcd_inc(hour_q, HOUR_MAX);
        end else if (do_dec) begin
          hour_d = bcd_dec(hour_q, HOUR_MAX);
        end
      end
      ST_SET_MIN: begin
        if (key_mode) begin
          state_d = ST_SET_SEC;
        end else if (do_inc) begin
          min_d = bcd_inc(min_q, MS_MAX);
        end else if (do_dec) begin
          min_d = bcd_dec(min_q, MS_MAX);
        end
      end
      ST_SET_SEC: begin
        if (key_mode) begin
          state_d = ST_RUN;
        end else if (do_inc) begin
          sec_d = bcd_inc(sec_q, MS_MAX);
        end else if (do_dec) begin
          sec_d = bcd_dec(sec_q, MS_MAX);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Count only while staying in RUN; anything else parks the prescaler at 0, so the
    // first tick after leaving SET_SEC comes a full CLK_DIV cycles later.
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !tick) begin
      presc_d = presc_q + 26'd1;
    end else begin
      presc_d = '0;
    end

    unique case (state_d)
      ST_SET_HOUR: twinkle_d = 6'b110000;
      ST_SET_MIN:  twinkle_d = 6'b001100;
      ST_SET_SEC:  twinkle_d = 6'b000011;
      default:     twinkle_d = 6'b000000;
    endcase

`ifdef CLOCK_SET_LZB_EN
    // Blank a leading zero hour digit, except while the hour field is being edited.
    enable_d = {(state_d == ST_SET_HOUR) || (hour_d[7:4] != 4'd0), 5'b11111};
`else
    enable_d = 6'b111111;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      hour_q    <= 8'h00;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      presc_q   <= '0;
      twinkle_q <= 6'b000000;
      enable_q  <= ENABLE_RST;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      twinkle_q <= twinkle_d;
      enable_q  <= enable_d;
    end
  end

  assign number_BCD = {hour_q, min_q, sec_q};
  assign enable     = enable_q;
  assign twinkle    = twinkle_q;
  assign set_mode   = state_q;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-of-day source for the six-digit seven-segment display. Keeps a 24-hour HH:MM:SS count in packed BCD, advanced by an internal one-second prescaler. Lets the user edit hours, minutes and seconds with three pre-debounced key pulses. Drives the display driver's `number_BCD`, `enable` and `twinkle` inputs directly, with the field being edited flagged for blinking.

## Interface
- `CLK_DIV`, default 50_000_000: clk cycles per second tick, must be ≥ 2; prescaler width 26 bits.
- `clk` input 1: system clock. One clock domain only; reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `key_mode` input 1: one-cycle pulse, already debounced; advances the edit state.
- `key_inc` input 1: one-cycle pulse; increments the selected field.
- `key_dec` input 1: one-cycle pulse; decrements the selected field.
- `number_BCD` output 24: {H1,H0,M1,M0,S1,S0}, 4 bits each; `[3:0]` = seconds units (rightmost digit).
- `enable` output 6: per-digit enable; bit i pairs with `number_BCD[4i+3:4i]`.
- `twinkle` output 6: per-digit blink request.
- `set_mode` output 2: current state. 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC.

## Operation
- **State machine.** Transitions happen on `key_mode` only: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- **Prescaler.**
  - Counts 0..`CLK_DIV`-1 in RUN only.
  - `tick` is asserted on the cycle the count equals `CLK_DIV`-1; the count then wraps to 0.
  - In any SET state the prescaler is held at 0.
- **RUN tick.** Seconds increment with BCD carry:
  - S 59→00 carries into minutes.
  - M 59→00 carries into hours.
  - 23:59:59→00:00:00.
  - Digits are never binary; each nibble stays 0–9, and tens digits stay within 0–5 for M/S and 0–2 for H.
- **SET states.** The time is frozen.
  - `key_inc` adds 1 to the selected field; `key_dec` subtracts 1.
  - Hours wrap 23↔00. Minutes and seconds wrap 59↔00.
  - No carry into neighbouring fields.
- **Priority within one cycle.**
  - `key_mode` beats `key_inc`/`key_dec`: the inc/dec is dropped.
  - `key_inc` together with `key_dec` is ignored.
  - inc/dec are ignored in RUN.
- **Tick coinciding with `key_mode` in RUN.** The tick is applied and the state moves to SET_HOUR in the same cycle.
- **Leaving SET_SEC.** The prescaler restarts from 0, so the first tick comes `CLK_DIV` cycles after returning to RUN.
- **`twinkle`.**
  - RUN: 6'b000000.
  - SET_HOUR: 6'b110000.
  - SET_MIN: 6'b001100.
  - SET_SEC: 6'b000011.
- **`enable`.** 6'b111111 unless altered by the Configuration macro.

## Timing
- All outputs are registered.
- A key pulse or tick sampled at edge N is visible on `number_BCD`/`twinkle`/`set_mode` after edge N, i.e. one cycle of latency.
- Reset values:
  - `number_BCD` = 24'h000000
  - `set_mode` = 0
  - `twinkle` = 6'b000000
  - `enable` = 6'b111111 (6'b011111 with the macro)
  - prescaler = 0
- Reset asserted mid-edit: it returns to RUN at 00:00:00 on the next edge and overrides all keys in that cycle.
- Key pulses are assumed to be at most one cycle wide. A held-high key acts once per cycle; there is no edge detection inside the block.

## Configuration
- Macro: `CLOCK_SET_LZB_EN`.
- **Defined:** leading-zero blanking of the hour tens digit.
  - `enable[5]` = 0 whenever H1 = 0, otherwise 1.
  - In SET_HOUR, `enable[5]` is forced to 1 so the edited field stays fully visible.
  - Registered together with `number_BCD`.
- **Undefined:** `enable` is constant 6'b111111.

## Test plan
- **Reset and first ticks.** `CLK_DIV`=4; release reset, run 12 cycles → `number_BCD` = 24'h000003, `set_mode` = 0, `twinkle` = 0.
- **Full rollover.** Preload via SET to 23:59:59, return to RUN, wait 4 cycles → 24'h000000 one cycle after the tick.
- **Hour field wrap.** In SET_HOUR:
  - `key_dec` from 00 → 24'h230000, `twinkle` = 6'b110000.
  - `key_inc` → 24'h000000.
  - Minutes and seconds unchanged.
- **Minute field wrap.** In SET_MIN at 00:59:30, `key_inc` → 24'h000030, with no carry into hours.
- **Simultaneous keys.**
  - `key_inc`+`key_dec` together → no change.
  - `key_mode`+`key_inc` in SET_MIN → state SET_SEC, minutes unchanged.
  - A tick coinciding with `key_mode` in RUN → seconds incremented and `set_mode` = 1.
- **Macro defined.**
  - At 09:00:00 → `enable` = 6'b011111.
  - In SET_HOUR → `enable` = 6'b111111.
  - At 10:00:00 → `enable` = 6'b111111.
  - Mid-edit `rst` → 00:00:00, RUN, `enable` = 6'b011111.
